// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb3lite_interconnect_slave_arbiter
//
// Per-slave-port arbiter of the AHB3-Lite multi-layer switch. It decides
// which master port owns the slave's address phase. The highest priority
// wins. Equal priorities are served round-robin, starting after the last
// winner. Ownership is held across bursts (can_switch) and across locked
// sequences (HMASTLOCK). The data-phase owner is tracked separately so that
// the HRDATA/HREADY/HRESP return mux stays steered through wait states.
//
// Ports:
//   HCLK            switch clock; all state changes on the rising edge
//   HRESETn         asynchronous active-low reset
//   mst_req         per-master request (HSEL for this slave and HTRANS != IDLE)
//   mst_priority    3-bit priority per master, master m at [3m+2:3m], 7 highest
//   mst_can_switch  per-master: last beat of a burst, or a single/IDLE transfer
//   mst_HMASTLOCK   per-master locked-transfer indication
//   slv_HREADY      combined slave HREADY; the address phase advances when 1
//   granted_master  one-hot address-phase owner (all zero = no owner)
//   granted_id      encoded granted_master (0 when there is no owner)
//   data_master     one-hot data-phase owner
//   data_valid      a data phase is in progress
// ---------------------------------------------------------------------------
module ahb3lite_interconnect_slave_arbiter #(
    parameter int MASTERS = 3,
    parameter int MIDX    = $clog2(MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [MASTERS-1:0]     mst_req,
    input  logic [3*MASTERS-1:0]   mst_priority,
    input  logic [MASTERS-1:0]     mst_can_switch,
    input  logic [MASTERS-1:0]     mst_HMASTLOCK,
    input  logic                   slv_HREADY,
    output logic [MASTERS-1:0]     granted_master,
    output logic [MIDX-1:0]        granted_id,
    output logic [MASTERS-1:0]     data_master,
    output logic                   data_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [MASTERS-1:0]   grant_q,  grant_d;
    logic [MIDX-1:0]      gid_q,    gid_d;
    logic [MIDX-1:0]      rr_q,     rr_d;
    logic [MASTERS-1:0]   dmaster_q;
    logic                 dvalid_q;

    logic [2:0]           pri [MASTERS];
    logic [2:0]           max_pri;
    logic [MASTERS-1:0]   elig;
    logic [MIDX-1:0]      win_hi;
    logic [MIDX-1:0]      win_lo;
    logic                 hi_found;
    logic [MIDX-1:0]      winner;
    logic [MASTERS-1:0]   win_onehot;
    logic                 any_req;
    logic                 arb;
    logic [MASTERS-1:0]   data_next;

    // Unpack the per-master priority fields.
    genvar gi;
    generate
        for (gi = 0; gi < MASTERS; gi++) begin : g_pri
            assign pri[gi]  = mst_priority[3*gi +: 3];
            assign elig[gi] = mst_req[gi] && (pri[gi] == max_pri);
        end
    endgenerate

    assign any_req = |mst_req;

    // Highest priority among the current requesters.
    always_comb begin
        max_pri = 3'd0;
        for (int m = 0; m < MASTERS; m++) begin
            if (mst_req[m] && (pri[m] > max_pri)) begin
                max_pri = pri[m];
            end
        end
    end

    // Round-robin pick among the top-priority requesters: the lowest index
    // above rr_q wins; if none exists, wrap and take the lowest index overall.
    // The descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        hi_found = 1'b0;
        for (int m = MASTERS - 1; m >= 0; m--) begin
            if (elig[m]) begin
                if (m > int'(rr_q)) begin
                    win_hi   = MIDX'(m);
                    hi_found = 1'b1;
                end else begin
                    win_lo = MIDX'(m);
                end
            end
        end
        winner = hi_found ? win_hi : win_lo;
    end

    assign win_onehot = {{(MASTERS-1){1'b0}}, 1'b1} << winner;

    // Arbitration opportunity: only while the address phase can advance, and
    // only when the current owner is free to be switched away.
    always_comb begin
        arb = 1'b0;
        if (slv_HREADY) begin
            case (state_q)
                ST_IDLE:   arb = 1'b1;
                ST_OWNED:  arb = mst_can_switch[gid_q] || !mst_req[gid_q];
                ST_LOCKED: arb = !mst_HMASTLOCK[gid_q] || !mst_req[gid_q];
                default:   arb = 1'b1;
            endcase
        end
    end

    // Next-state and grant update.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        if (arb) begin
            if (any_req) begin
                grant_d = win_onehot;
                gid_d   = winner;
                rr_d    = winner;
                state_d = mst_HMASTLOCK[winner] ? ST_LOCKED : ST_OWNED;
            end else begin
                grant_d = '0;
                gid_d   = '0;
                state_d = ST_IDLE;
            end
        end
    end

    // The data phase belongs to whoever owned the address phase on the edge
    // it advanced, provided that master was actually issuing a transfer.
    assign data_next = grant_q & mst_req;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gid_q     <= '0;
            rr_q      <= MIDX'(MASTERS - 1);
            dmaster_q <= '0;
            dvalid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            if (slv_HREADY) begin
                dmaster_q <= data_next;
                dvalid_q  <= |data_next;
            end
        end
    end

    assign granted_master = grant_q;
    assign granted_id     = gid_q;
    assign data_master    = dmaster_q;
    assign data_valid     = dvalid_q;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for ahb3lite_interconnect_slave_arbiter (MASTERS=3).
// A driver applies directed then random stimulus on the falling edge and
// pushes the expected outputs of the following rising edge (or of an
// asynchronous reset) into a queue; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ahb3lite_interconnect_slave_arbiter;

    localparam int M  = 3;
    localparam int MI = $clog2(M);

    logic              HCLK = 1'b0;
    logic              HRESETn = 1'b0;
    logic [M-1:0]      mst_req = '0;
    logic [3*M-1:0]    mst_priority = '0;
    logic [M-1:0]      mst_can_switch = '0;
    logic [M-1:0]      mst_HMASTLOCK = '0;
    logic              slv_HREADY = 1'b0;
    logic [M-1:0]      granted_master;
    logic [MI-1:0]     granted_id;
    logic [M-1:0]      data_master;
    logic              data_valid;

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(M)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .mst_req        (mst_req),
        .mst_priority   (mst_priority),
        .mst_can_switch (mst_can_switch),
        .mst_HMASTLOCK  (mst_HMASTLOCK),
        .slv_HREADY     (slv_HREADY),
        .granted_master (granted_master),
        .granted_id     (granted_id),
        .data_master    (data_master),
        .data_valid     (data_valid)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [M-1:0]  gm;
        logic [MI-1:0] gid;
        logic [M-1:0]  dm;
        logic          dv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_trans  = 0;
    logic pending_release = 1'b0;

    // Reference model: owner/data owner as plain indices (-1 = none).
    int   m_owner;
    int   m_data;
    int   m_rr;
    bit   m_locked;

    function automatic logic [3*M-1:0] pri3(input int p0, input int p1, input int p2);
        return {3'(p2), 3'(p1), 3'(p0)};
    endfunction

    function automatic int pri_of(input int m);
        logic [3*M-1:0] v;
        v = mst_priority;
        return int'(v[3*m +: 3]);
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_data   = -1;
        m_rr     = M - 1;
        m_locked = 1'b0;
    endtask

    // Advance the model over one rising edge with the inputs now applied.
    task automatic model_step();
        bit arb;
        int best;
        int best_key;
        int key;
        if (!slv_HREADY)            arb = 1'b0;
        else if (m_owner < 0)       arb = 1'b1;
        else if (!mst_req[m_owner]) arb = 1'b1;
        else if (m_locked)          arb = !mst_HMASTLOCK[m_owner];
        else                        arb = mst_can_switch[m_owner];

        if (slv_HREADY) begin
            m_data = (m_owner >= 0 && mst_req[m_owner]) ? m_owner : -1;
        end

        if (arb) begin
            if (mst_req == '0) begin
                m_owner  = -1;
                m_locked = 1'b0;
            end else begin
                // Rank: priority first, then distance after the last winner.
                best     = -1;
                best_key = 1 << 30;
                for (int m = 0; m < M; m++) begin
                    if (mst_req[m]) begin
                        key = (7 - pri_of(m)) * M + ((m - m_rr - 1 + 2 * M) % M);
                        if (key < best_key) begin
                            best_key = key;
                            best     = m;
                        end
                    end
                end
                m_owner  = best;
                m_rr     = best;
                m_locked = mst_HMASTLOCK[best];
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.gm  = '0;
        e.gid = '0;
        e.dm  = '0;
        e.dv  = 1'b0;
        if (m_owner >= 0) begin
            e.gm[m_owner] = 1'b1;
            e.gid         = MI'(m_owner);
        end
        if (m_data >= 0) begin
            e.dm[m_data] = 1'b1;
            e.dv         = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [M-1:0] r, input logic [3*M-1:0] p,
                         input logic [M-1:0] c, input logic [M-1:0] l,
                         input logic h);
        @(negedge HCLK);
        if (pending_release) begin
            HRESETn         = 1'b1;
            pending_release = 1'b0;
        end
        mst_req        = r;
        mst_priority   = p;
        mst_can_switch = c;
        mst_HMASTLOCK  = l;
        slv_HREADY     = h;
        if (!HRESETn) model_reset();
        else          model_step();
        push_expect();
    endtask

    // Assert reset between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(negedge HCLK);
        #2;
        model_reset();
        push_expect();
        HRESETn = 1'b0;
    endtask

    task automatic check_field(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s txn=%0d t=%0t actual=%0h required=%0h", name, n_trans, $time, act, req);
        end
    endtask

    // Monitor: one comparison set per expected entry.
    initial begin
        forever begin
            @(posedge HCLK or negedge HRESETn);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_trans++;
                $display("txn %0d t=%0t gm=%b gid=%0d dm=%b dv=%b (exp gm=%b gid=%0d dm=%b dv=%b)",
                         n_trans, $time, granted_master, granted_id, data_master, data_valid,
                         mon_e.gm, mon_e.gid, mon_e.dm, mon_e.dv);
                check_field("granted_master", int'(granted_master), int'(mon_e.gm));
                check_field("granted_id",     int'(granted_id),     int'(mon_e.gid));
                check_field("data_master",    int'(data_master),    int'(mon_e.dm));
                check_field("data_valid",     int'(data_valid),     int'(mon_e.dv));
            end
        end
    end

    // Driver
    initial begin
        logic [M-1:0]   r, c, l;
        logic [3*M-1:0] p;
        int             waited;
        model_reset();

        // Reset state
        cycle('0, '0, '0, '0, 1'b1);
        cycle('0, '0, '0, '0, 1'b1);
        pending_release = 1'b1;

        // Single requester, then none
        repeat (3) cycle(3'b001, pri3(0, 0, 0), 3'b111, 3'b000, 1'b1);
        repeat (2) cycle(3'b000, pri3(0, 0, 0), 3'b111, 3'b000, 1'b1);

        // Priority
        repeat (2) cycle(3'b111, pri3(1, 5, 3), 3'b111, 3'b000, 1'b1);
        repeat (2) cycle(3'b111, pri3(1, 5, 6), 3'b111, 3'b000, 1'b1);

        // Round-robin at equal priority
        repeat (5) cycle(3'b111, pri3(2, 2, 2), 3'b111, 3'b000, 1'b1);

        // Burst hold: m0 owner, can_switch low while m1 outranks it
        cycle(3'b000, pri3(0, 7, 0), 3'b111, 3'b000, 1'b1);
        cycle(3'b001, pri3(0, 7, 0), 3'b111, 3'b000, 1'b1);
        repeat (4) cycle(3'b011, pri3(0, 7, 0), 3'b110, 3'b000, 1'b1);
        repeat (2) cycle(3'b011, pri3(0, 7, 0), 3'b111, 3'b000, 1'b1);

        // Lock: m0 granted with HMASTLOCK, m1 at priority 7 waits
        cycle(3'b000, pri3(0, 7, 0), 3'b111, 3'b000, 1'b1);
        cycle(3'b001, pri3(0, 7, 0), 3'b111, 3'b001, 1'b1);
        repeat (3) cycle(3'b011, pri3(0, 7, 0), 3'b111, 3'b001, 1'b1);
        repeat (2) cycle(3'b011, pri3(0, 7, 0), 3'b111, 3'b000, 1'b1);

        // Wait states: everything holds
        repeat (3) cycle(3'b101, pri3(7, 0, 7), 3'b111, 3'b000, 1'b0);
        cycle(3'b101, pri3(7, 0, 7), 3'b111, 3'b000, 1'b1);
        cycle(3'b010, pri3(7, 0, 7), 3'b111, 3'b000, 1'b0);

        // Asynchronous reset mid-burst of m1
        repeat (3) cycle(3'b010, pri3(0, 3, 0), 3'b000, 3'b000, 1'b1);
        async_reset();
        repeat (2) cycle(3'b111, pri3(4, 4, 4), 3'b000, 3'b000, 1'b1);
        pending_release = 1'b1;
        repeat (3) cycle(3'b111, pri3(4, 4, 4), 3'b000, 3'b000, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = M'($urandom);
            c = M'($urandom);
            l = '0;
            for (int m = 0; m < M; m++) begin
                l[m] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 3) == 0) p = pri3(2, 2, 2);
            else p = pri3($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            cycle(r, p, c, l, ($urandom_range(0, 9) < 8));
        end

        // Drain the scoreboard within a bounded number of cycles.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge HCLK);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
